spi_mul_master: RTL

SPI_MUL_MASTER -- requirements
Module: spi_mul_master

---
 rtl/spi_mul_master_if.sv | 24 ++
 rtl/spi_mul_master.sv | 135 +++++++++++++
 2 files changed

// File: rtl/spi_mul_master_if.sv
// rtl/spi_mul_master_if.sv - host and SPI signal bundle for the serial multiplier master
interface spi_mul_master_if;
  logic        start;
  logic [2:0]  opcode;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        nss;
  logic        sclk;
  logic        mosi;
  logic        miso;

  modport master (
    input  start, opcode, opa, opb, miso,
    output busy, done, result, nss, sclk, mosi
  );

  modport slave (
    output start, opcode, opa, opb, miso,
    input  busy, done, result, nss, sclk, mosi
  );
endinterface

// File: rtl/spi_mul_master.sv
// rtl/spi_mul_master.sv - SPI master sending a 67-bit command frame and reading back a 32-bit result
module spi_mul_master #(
  parameter int HALF_DIV   = 1,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  spi_mul_master_if.master  bus
);

  localparam int CMAX = (HALF_DIV > GAP_CYCLES) ? HALF_DIV : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, TX, GAP, RX, DONE} state_t;

  state_t          state;
  logic [66:0]     sh;
  logic [31:0]     rsh;
  logic [6:0]      bit_cnt;
  logic [CW-1:0]   div_cnt;
  logic            busy_r;
  logic            done_r;
  logic [31:0]     result_r;
  logic            nss_r;
  logic            sclk_r;
  logic            mosi_r;

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.nss    = nss_r;
  assign bus.sclk   = sclk_r;
  assign bus.mosi   = mosi_r;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sh       <= '0;
      rsh      <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
      nss_r    <= 1'b1;
      sclk_r   <= 1'b0;
      mosi_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh      <= {bus.opcode, bus.opa, bus.opb};
            mosi_r  <= bus.opcode[2];
            nss_r   <= 1'b0;
            sclk_r  <= 1'b0;
            busy_r  <= 1'b1;
            div_cnt <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            state   <= TX;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        TX: begin
          if (div_cnt != HALF_LAST) begin
            div_cnt <= div_cnt + CW'(1);
          end else begin
            div_cnt <= '0;
            if (!sclk_r) begin
              sclk_r <= 1'b1;
            end else if (bit_cnt == 7'd66) begin
              sclk_r <= 1'b0;
              nss_r  <= 1'b1;
              mosi_r <= 1'b0;
              state  <= GAP;
            end else begin
              // rotate so the next bit lands in sh[66]; mosi only moves on the falling edge
              sclk_r  <= 1'b0;
              mosi_r  <= sh[65];
              sh      <= {sh[65:0], sh[66]};
              bit_cnt <= bit_cnt + 7'd1;
            end
          end
        end
        GAP: begin
          if (div_cnt == GAP_LAST) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            nss_r   <= 1'b0;
            state   <= RX;
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end
        RX: begin
          if (div_cnt != HALF_LAST) begin
            div_cnt <= div_cnt + CW'(1);
          end else begin
            div_cnt <= '0;
            if (!sclk_r) begin
              sclk_r <= 1'b1;
              rsh    <= {rsh[30:0], bus.miso};
            end else if (bit_cnt == 7'd31) begin
              sclk_r   <= 1'b0;
              nss_r    <= 1'b1;
              result_r <= rsh;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              state    <= DONE;
            end else begin
              sclk_r  <= 1'b0;
              bit_cnt <= bit_cnt + 7'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
